// File: rtl/hv_pkg.sv
// Shared types and helpers for the hypervector encode core: mode and FSM state
// encodings plus a width-generic rotate-right helper.
package hv_pkg;

   typedef enum logic [1:0] {
      HV_ADD     = 2'd0,
      HV_XOR_ROT = 2'd1,
      HV_BUNDLE  = 2'd2,
      HV_RSVD    = 2'd3
   } hv_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } hv_state_t;

   // Largest hypervector width the rotate helper handles.
   localparam int HV_MAX_W  = 256;
   localparam int HV_MAX_AW = $clog2(HV_MAX_W);

   // Rotate the low `width` bits of vec right by amt (amt < width); bits above width are zero.
   function automatic logic [HV_MAX_W-1:0] hv_rotr(input logic [HV_MAX_W-1:0] vec,
                                                   input int amt,
                                                   input int width);
      logic [HV_MAX_W-1:0] res;
      int idx;
      res = '0;
      for (int i = 0; i < HV_MAX_W; i++) begin
         if (i < width) begin
            idx = i + amt;
            if (idx >= width) idx = idx - width;
            res[HV_MAX_AW'(i)] = vec[HV_MAX_AW'(idx)];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hv_encode_core_if.sv
// Symbol-in / result-out stream bundle of the hypervector encode core.
// The core uses the slave modport, the symbol producer / result consumer the master modport.
interface hv_encode_core_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 7,
   parameter int CNT_W = 8
) ();
   logic             sym_valid;
   logic             sym_ready;
   logic [AW-1:0]    sym_data;
   logic             sym_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_count;

   modport master (
      output sym_valid, sym_data, sym_last, out_ready,
      input  sym_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  sym_valid, sym_data, sym_last, out_ready,
      output sym_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/hv_item_mem.sv
// Item memory: single write port, registered read port, block RAM.
// Power-up content is mem[i] = i; out-of-range reads return zero, out-of-range writes drop.
module hv_item_mem
   import hv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 100
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   function automatic logic [DEPTH-1:0][WIDTH-1:0] mem_init();
      for (int i = 0; i < DEPTH; i++) mem_init[AW'(i)] = WIDTH'(i);
   endfunction

   (* ram_style = "block" *) logic [DEPTH-1:0][WIDTH-1:0] mem = mem_init();

   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < DEPTH_W)) mem[waddr] <= wdata;
      if (re) rdata <= ({1'b0, raddr} < DEPTH_W) ? mem[raddr] : '0;
   end

endmodule

// File: rtl/hv_encode_core.sv
// Hypervector encode core: streams symbol indices through the item memory and folds them
// into one hypervector (add, xor-bind with rotation, or majority bundle when HV_BUNDLE_EN is defined).
//
// state | meaning
// IDLE  | waiting for the first symbol; item memory writable
// RUN   | accepting symbols, applying the previous symbol's memory word
// DRAIN | applying the final memory word and registering the result
// OUT   | result presented until out_ready
module hv_encode_core
   import hv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 100,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               cfg_mode,
   input  logic                     mem_we,
   input  logic [$clog2(DEPTH)-1:0] mem_addr,
   input  logic [WIDTH-1:0]         mem_wdata,
   hv_encode_core_if.slave          bus,
   output logic                     err_oob,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(WIDTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   hv_state_t        state_q, state_d;
   hv_mode_t         mode_q;
   logic             ready_c, valid_c, accept, start, oob_c;
   logic             pend_v;
   logic [PW-1:0]    pend_pos, pos_q, pos_inc;
   logic [WIDTH-1:0] acc_q, acc_d, res_d, rot, rdata, out_data_q;
   logic [CNT_W-1:0] cnt_sym_q;
   logic             err_oob_q;

   function automatic hv_mode_t eff_mode(input logic [1:0] m);
      hv_mode_t r;
      case (m)
         2'd1:    r = HV_XOR_ROT;
`ifdef HV_BUNDLE_EN
         2'd2:    r = HV_BUNDLE;
`else
         2'd2:    r = HV_XOR_ROT;
`endif
         default: r = HV_ADD;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = !mem_we && !rst;
            if (bus.sym_valid && ready_c) state_d = bus.sym_last ? DRAIN : RUN;
         end
         RUN: begin
            ready_c = 1'b1;
            if (bus.sym_valid && bus.sym_last) state_d = DRAIN;
         end
         DRAIN: state_d = OUT;
         OUT: begin
            valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept  = bus.sym_valid && ready_c;
   assign start   = accept && (state_q == IDLE);
   assign oob_c   = ({1'b0, bus.sym_data} >= DEPTH_W);
   assign pos_inc = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);

   hv_item_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (mem_we && (state_q == IDLE)),
      .waddr (mem_addr),
      .wdata (mem_wdata),
      .re    (accept),
      .raddr (bus.sym_data),
      .rdata (rdata)
   );

   // rdata belongs to the symbol accepted on the previous cycle, at position pend_pos.
   assign rot = WIDTH'(hv_rotr(HV_MAX_W'(rdata), 32'(pend_pos), WIDTH));

   always_comb begin
      acc_d = acc_q;
      if (pend_v) begin
         if (mode_q == HV_XOR_ROT) acc_d = acc_q ^ rot;
         else                      acc_d = acc_q + rdata;
      end
   end

`ifdef HV_BUNDLE_EN
   logic [CNT_W-1:0] bcnt_q [WIDTH];
   logic [CNT_W-1:0] bcnt_d [WIDTH];
   logic [WIDTH-1:0] bin_d;

   always_comb begin
      bin_d = '0;
      for (int b = 0; b < WIDTH; b++) begin
         bcnt_d[PW'(b)] = bcnt_q[PW'(b)];
         if (pend_v && (mode_q == HV_BUNDLE) && rot[PW'(b)] && (bcnt_q[PW'(b)] != '1))
            bcnt_d[PW'(b)] = bcnt_q[PW'(b)] + CNT_W'(1);
         // Strict majority: ties resolve to 0.
         bin_d[PW'(b)] = ({bcnt_d[PW'(b)], 1'b0} > {1'b0, cnt_sym_q});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < WIDTH; b++) bcnt_q[PW'(b)] <= '0;
      end else if (start) begin
         for (int b = 0; b < WIDTH; b++) bcnt_q[PW'(b)] <= '0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end

   assign res_d = (mode_q == HV_BUNDLE) ? bin_d : acc_d;
`else
   assign res_d = acc_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= HV_ADD;
         pend_v     <= 1'b0;
         pend_pos   <= '0;
         pos_q      <= '0;
         acc_q      <= '0;
         cnt_sym_q  <= '0;
         err_oob_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         pend_v <= accept;
         if (accept) pend_pos <= start ? '0 : pos_q;
         if (start) begin
            mode_q    <= eff_mode(cfg_mode);
            acc_q     <= '0;
            cnt_sym_q <= CNT_W'(1);
            err_oob_q <= oob_c;
            pos_q     <= PW'(1);
         end else begin
            acc_q <= acc_d;
            if (accept) begin
               pos_q <= pos_inc;
               if (cnt_sym_q != '1) cnt_sym_q <= cnt_sym_q + CNT_W'(1);
               if (oob_c) err_oob_q <= 1'b1;
            end
         end
         if (state_q == DRAIN) out_data_q <= res_d;
      end
   end

   assign bus.sym_ready = ready_c;
   assign bus.out_valid = valid_c;
   assign bus.out_data  = valid_c ? out_data_q : '0;
   assign bus.out_count = cnt_sym_q;
   assign err_oob       = err_oob_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: doc/hv_encode_core.md
Name: hv_encode_core

Overview:
- Parametrised successor to the single-lane HPU core.
- Per-core item memory (block RAM) maps symbol indices to WIDTH-bit hypervectors.
- Streams symbols in and encodes each sequence into one hypervector using one of three modes: additive accumulate, XOR-bind with rotate permutation, or per-bit majority bundling.
- The result is returned on a valid/ready output port; instantiated once per HPU lane.

Parameters:
- WIDTH, 32: hypervector width in bits (≥2).
- DEPTH, 100: item memory entries.
- AW, $clog2(DEPTH) (derived localparam, not overridable): symbol/address width.
- CNT_W, 8: symbol counter and per-bit bundle counter width.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- cfg_mode  in  2: encode mode. Sampled on the first accepted symbol of a sequence.
- mem_we  in  1: item memory write strobe.
- mem_addr  in  AW: item memory write address.
- mem_wdata  in  WIDTH: item memory write data.
- sym_valid  in  1: symbol valid.
- sym_ready  out  1: symbol ready.
- sym_data  in  AW: symbol index.
- sym_last  in  1: marks the final symbol of a sequence.
- out_valid  out  1: result valid.
- out_ready  in  1: result accepted.
- out_data  out  WIDTH: encoded hypervector. Zero whenever out_valid=0.
- out_count  out  CNT_W: number of symbols in the sequence; saturating.
- err_oob  out  1: sticky flag, a symbol index ≥ DEPTH was seen.
- busy  out  1: state != IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; sym_ready, out_valid, err_oob, busy = 0; out_data=0; out_count=0.
  - Accumulator, counters and pos cleared.
  - Item memory contents are not reset.
  - Power-up memory content is mem[i] = i, zero-extended/truncated to WIDTH.
- FSM states are IDLE, RUN, DRAIN, OUT.
- IDLE:
  - sym_ready = !mem_we.
  - mem_we writes mem[mem_addr] = mem_wdata. Writes with addr ≥ DEPTH are dropped.
  - An accepted symbol moves to RUN, latches mode, clears acc/counters/err_oob and sets pos=0.
  - If that symbol has sym_last=1, go directly to DRAIN.
- RUN:
  - sym_ready=1.
  - Each accepted symbol issues a synchronous read: data arrives 1 cycle later.
  - The accepted symbol is then applied with its pos; pos increments per accept, modulo WIDTH.
  - Accepting sym_last → DRAIN.
  - mem_we is ignored in RUN, DRAIN and OUT (no write, no error).
- DRAIN:
  - One cycle; sym_ready=0.
  - The final read is applied.
  - For bundle mode, the binarisation is registered.
  - Next state is OUT.
- OUT:
  - out_valid=1; out_data/out_count held stable while out_ready=0.
  - On out_valid & out_ready → IDLE.
- Latency: last symbol accept at cycle t → out_valid at t+2.
- Throughput: 1 symbol/cycle.
- Symbol application (m = mem[sym], or 0 if sym ≥ DEPTH, which also sets err_oob; r = rotate-right(m, pos)):
  - HV_ADD: acc = acc + m, mod 2^WIDTH, no rotation.
  - HV_XOR_ROT: acc = acc ^ r.
  - HV_BUNDLE: for each bit b, cnt[b] += r[b], saturating at 2^CNT_W-1. Output bit b = (2·cnt[b] > out_count). Ties give 0.
  - Mode 3 is reserved and behaves as HV_ADD.
- out_count increments per accepted symbol and saturates at 2^CNT_W-1.
- cfg_mode changes mid-sequence are ignored.
- Reset mid-sequence discards the partial result. No out_valid pulse is produced.

Optional Feature:
- Macro HV_BUNDLE_EN.
- Defined: HV_BUNDLE mode and the WIDTH×CNT_W counter array are built.
- Undefined: the counter array is not instantiated, and mode 2 behaves as HV_XOR_ROT.

Decomposition:
- Package hv_pkg holds:
  - hv_mode_t: HV_ADD=2'd0, HV_XOR_ROT=2'd1, HV_BUNDLE=2'd2, HV_RSVD=2'd3.
  - hv_state_t: IDLE, RUN, DRAIN, OUT.
  - Function hv_rotr(vec, amt), parametrised by width.
- One sub-module: hv_item_mem, a single-port-write/sync-read BRAM with ram_style="block" and the index-value initial content.

Test Plan:
- ADD: default memory; send 3, 5, 7(last) → out_data=0x0000000F, out_count=3, out_valid 2 cycles after the last accept.
- XOR_ROT: send 1, 1, 1(last) → terms 0x00000001, 0x80000000, 0x40000000 → out_data=0xC0000001.
- BUNDLE (HV_BUNDLE_EN): send 1, 3, 2(last) → rotated terms 0x00000001, 0x80000001, 0x80000000. Bits 0 and 31 count 2 of 3 → out_data=0x80000001. Without the macro, the same stimulus gives 0x00000000.
- Memory write:
  - Write mem[5]=0xDEADBEEF in IDLE, then ADD with symbol 5(last) → 0xDEADBEEF.
  - A write of mem[5]=0 issued during RUN is ignored; a repeat sequence still gives 0xDEADBEEF.
  - sym_ready=0 in the write cycle.
- OOB: ADD with 120, 4(last) → out_data=4, err_oob=1. err_oob clears on the next sequence start.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles → out_data/out_count stable, sym_ready=0.
  - Assert rst mid-RUN → out_valid=0, busy=0 immediately; the next ADD sequence 2(last) gives out_data=2.
